// File: rtl/em_buf_chain_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : em_buf_chain_reader_pkg
// Brief    : Shared widths and FSM encoding for the edit-memory chain reader.
// Revision : 1.0 - initial release
// ============================================================================
package em_buf_chain_reader_pkg;

  // Default datapath widths shared with the rest of the dequeue side.
  localparam int EM_BUF_PTR_NBITS     = 8;
  localparam int PORT_ID_NBITS        = 4;
  localparam int PD_CHUNK_DEPTH_NBITS = 12;
  localparam int DATA_PATH_NBYTES     = 16;

  // FSM encoding, reusable by other dequeue blocks walking buffer chains.
  localparam int EM_CHAIN_ST_NBITS = 2;

  typedef enum logic [EM_CHAIN_ST_NBITS-1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_WAIT = 2'd2
  } em_chain_st_e;

endpackage
`default_nettype wire

// File: rtl/em_buf_chain_reader.sv
`default_nettype none
// ============================================================================
// Module   : em_buf_chain_reader
// Brief    : Walks a packet's buffer chain in edit memory, emitting one read
//            command per buffer and fetching each successor pointer from the
//            linked list with a single outstanding request.
// Revision : 1.0 - initial release
// ============================================================================
module em_buf_chain_reader
  import em_buf_chain_reader_pkg::*;
#(
  parameter int BPTR_NBITS = EM_BUF_PTR_NBITS,
  parameter int ID_NBITS   = PORT_ID_NBITS,
  parameter int LEN_NBITS  = PD_CHUNK_DEPTH_NBITS,
  parameter int SIZE       = DATA_PATH_NBYTES,
  parameter int BC_NBITS   = $clog2(SIZE) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  // descriptor input
  input  logic                  desc_valid,
  output logic                  desc_ready,
  input  logic [BPTR_NBITS-1:0] desc_buf_ptr,
  input  logic [ID_NBITS-1:0]   desc_port_id,
  input  logic [LEN_NBITS-1:0]  desc_len,
  // linked-list request / acknowledge
  output logic                  buf_req,
  output logic [BPTR_NBITS-1:0] buf_req_ptr,
  input  logic                  buf_ack_valid,
  input  logic [BPTR_NBITS-1:0] buf_ack_ptr,
  // read command output
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [BPTR_NBITS-1:0] rd_buf_ptr,
  output logic [ID_NBITS-1:0]   rd_port_id,
  output logic                  rd_sop,
  output logic                  rd_eop,
  output logic [BC_NBITS-1:0]   rd_bytes,
  // status
  output logic                  desc_drop,
  output logic                  err_ack,
  output logic                  busy
);

  localparam logic [LEN_NBITS-1:0] c_size_len = LEN_NBITS'(SIZE);
  localparam logic [BC_NBITS-1:0]  c_size_bc  = BC_NBITS'(SIZE);

  em_chain_st_e           state_q, state_d;
  logic [BPTR_NBITS-1:0]  cur_ptr_q, cur_ptr_d;
  logic [ID_NBITS-1:0]    port_q, port_d;
  logic [LEN_NBITS-1:0]   rem_q, rem_d;
  logic                   first_q, first_d;
  logic                   buf_req_q, buf_req_d;
  logic [BPTR_NBITS-1:0]  buf_req_ptr_q, buf_req_ptr_d;
  logic                   desc_drop_q, desc_drop_d;
  logic                   err_ack_q, err_ack_d;
  // Held low through reset so desc_ready reads 0 while rst is applied.
  logic                   init_q, init_d;

  // Read command and status decode from registered state and data.
  assign desc_ready  = (state_q == ST_IDLE) && init_q;
  assign rd_valid    = (state_q == ST_EMIT);
  assign rd_buf_ptr  = cur_ptr_q;
  assign rd_port_id  = port_q;
  assign rd_sop      = first_q;
  assign rd_eop      = (rem_q <= c_size_len);
  // rem never exceeds SIZE at EOP, so truncation to the byte-count width is safe.
  assign rd_bytes    = rd_eop ? rem_q[BC_NBITS-1:0] : c_size_bc;
  assign busy        = (state_q != ST_IDLE);
  assign buf_req     = buf_req_q;
  assign buf_req_ptr = buf_req_ptr_q;
  assign desc_drop   = desc_drop_q;
  assign err_ack     = err_ack_q;

  // Next-state, datapath update and registered-pulse generation.
  always_comb begin
    state_d       = state_q;
    cur_ptr_d     = cur_ptr_q;
    port_d        = port_q;
    rem_d         = rem_q;
    first_d       = first_q;
    buf_req_d     = 1'b0;
    buf_req_ptr_d = buf_req_ptr_q;
    desc_drop_d   = 1'b0;
    init_d        = 1'b1;
    // An ack is only legal while waiting; anywhere else it is flagged and ignored.
    err_ack_d     = buf_ack_valid && (state_q != ST_WAIT);

    case (state_q)
      ST_IDLE: begin
        if (desc_valid && desc_ready) begin
          cur_ptr_d = desc_buf_ptr;
          port_d    = desc_port_id;
          rem_d     = desc_len;
          first_d   = 1'b1;
          if (desc_len == '0) begin
            desc_drop_d = 1'b1;
          end else begin
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (rd_ready) begin
          if (rd_eop) begin
            // The last buffer's successor is never fetched.
            state_d = ST_IDLE;
          end else begin
            rem_d         = rem_q - c_size_len;
            first_d       = 1'b0;
            buf_req_d     = 1'b1;
            buf_req_ptr_d = cur_ptr_q;
            state_d       = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (buf_ack_valid) begin
          cur_ptr_d = buf_ack_ptr;
          state_d   = ST_EMIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cur_ptr_q     <= '0;
      port_q        <= '0;
      rem_q         <= '0;
      first_q       <= 1'b0;
      buf_req_q     <= 1'b0;
      buf_req_ptr_q <= '0;
      desc_drop_q   <= 1'b0;
      err_ack_q     <= 1'b0;
      init_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_ptr_q     <= cur_ptr_d;
      port_q        <= port_d;
      rem_q         <= rem_d;
      first_q       <= first_d;
      buf_req_q     <= buf_req_d;
      buf_req_ptr_q <= buf_req_ptr_d;
      desc_drop_q   <= desc_drop_d;
      err_ack_q     <= err_ack_d;
      init_q        <= init_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_em_buf_chain_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_em_buf_chain_reader
// Brief    : Scoreboard bench for em_buf_chain_reader with a linked-list model
//            (next-pointer memory plus 4-cycle ack pipe).
// Revision : 1.0 - initial release
// ============================================================================
module tb_em_buf_chain_reader;

  localparam int BP = 8;
  localparam int ID = 4;
  localparam int LN = 12;
  localparam int SZ = 16;
  localparam int BC = 5;

  typedef struct packed {
    logic [BP-1:0] ptr;
    logic [ID-1:0] port;
    logic          sop;
    logic          eop;
    logic [BC-1:0] bytes;
  } rd_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          desc_valid, desc_ready;
  logic [BP-1:0] desc_buf_ptr;
  logic [ID-1:0] desc_port_id;
  logic [LN-1:0] desc_len;
  logic          buf_req;
  logic [BP-1:0] buf_req_ptr;
  logic          buf_ack_valid;
  logic [BP-1:0] buf_ack_ptr;
  logic          rd_valid, rd_ready;
  logic [BP-1:0] rd_buf_ptr;
  logic [ID-1:0] rd_port_id;
  logic          rd_sop, rd_eop;
  logic [BC-1:0] rd_bytes;
  logic          desc_drop, err_ack, busy;

  int  n_assert = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  last_rd_cyc = 0;
  int  err_cnt  = 0;
  int  drop_cnt = 0;
  bit  spacing_en = 1'b1;
  bit  eop_pending = 1'b0;
  bit  drop_pending = 1'b0;

  rd_t           exp_rd[$];
  logic [BP-1:0] exp_req[$];
  logic [BP-1:0] chain_mem [256];
  logic [3:0]    ack_pipe;
  logic [BP-1:0] ptr_pipe [4];

  em_buf_chain_reader dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_buf_ptr(desc_buf_ptr), .desc_port_id(desc_port_id), .desc_len(desc_len),
    .buf_req(buf_req), .buf_req_ptr(buf_req_ptr),
    .buf_ack_valid(buf_ack_valid), .buf_ack_ptr(buf_ack_ptr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_buf_ptr(rd_buf_ptr),
    .rd_port_id(rd_port_id), .rd_sop(rd_sop), .rd_eop(rd_eop), .rd_bytes(rd_bytes),
    .desc_drop(desc_drop), .err_ack(err_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Linked-list model: ack arrives four cycles after the request pulse and is
  // deliberately independent of the DUT reset.
  assign buf_ack_valid = ack_pipe[3];
  assign buf_ack_ptr   = ptr_pipe[3];
  always @(posedge clk) begin
    ack_pipe    <= {ack_pipe[2:0], buf_req};
    ptr_pipe[0] <= chain_mem[buf_req_ptr];
    ptr_pipe[1] <= ptr_pipe[0];
    ptr_pipe[2] <= ptr_pipe[1];
    ptr_pipe[3] <= ptr_pipe[2];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Read-command and request scoreboard, status pulse tracking.
  always @(negedge clk) begin
    if (eop_pending) begin
      chk("idle_after_eop", {30'd0, desc_ready, busy}, 32'h2);
      eop_pending = 1'b0;
    end
    if (drop_pending || desc_drop) begin
      chk("desc_drop_timing", {31'd0, desc_drop}, {31'd0, drop_pending});
      drop_pending = 1'b0;
    end
    if (desc_drop) drop_cnt++;
    if (err_ack) err_cnt++;
    if (!rst && desc_valid && desc_ready && desc_len == '0) drop_pending = 1'b1;
    if (buf_req) begin
      if (exp_req.size() == 0) chk("buf_req_unexp", 32'd1, 32'd0);
      else chk("buf_req_ptr", {24'd0, buf_req_ptr}, {24'd0, exp_req.pop_front()});
    end
    if (rd_valid && rd_ready) begin
      if (exp_rd.size() == 0) begin
        chk("rd_unexp", 32'd1, 32'd0);
      end else begin
        rd_t e;
        e = exp_rd.pop_front();
        chk("rd_cmd", {13'd0, rd_buf_ptr, rd_port_id, rd_sop, rd_eop, rd_bytes}, {13'd0, e});
        if (!e.sop && spacing_en) chk("rd_spacing", cyc - last_rd_cyc, 32'd6);
        last_rd_cyc = cyc;
        if (rd_eop) eop_pending = 1'b1;
      end
    end
  end

  task automatic send_desc(input logic [BP-1:0] ptr, input logic [ID-1:0] port,
                           input logic [LN-1:0] len);
    logic [BP-1:0] p;
    int rem;
    bit accepted;
    rd_t r;
    p = ptr;
    rem = int'(len);
    while (rem > 0) begin
      r.ptr = p; r.port = port; r.sop = (p == ptr) && (rem == int'(len));
      r.eop = (rem <= SZ);
      r.bytes = r.eop ? BC'(rem) : BC'(SZ);
      exp_rd.push_back(r);
      if (!r.eop) begin
        exp_req.push_back(p);
        p = chain_mem[p];
      end
      rem -= SZ;
    end
    @(posedge clk); #1;
    desc_valid = 1'b1; desc_buf_ptr = ptr; desc_port_id = port; desc_len = len;
    accepted = 1'b0;
    for (int i = 0; i < 100 && !accepted; i++) begin
      @(negedge clk);
      if (desc_ready) accepted = 1'b1;
      @(posedge clk); #1;
    end
    desc_valid = 1'b0;
    if (!accepted) chk("desc_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (!busy && exp_rd.size() == 0 && exp_req.size() == 0) done = 1'b1;
    end
    if (!done) chk("idle_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {26'd0, desc_ready, buf_req, rd_valid, desc_drop, err_ack, busy}, 32'd0);
  endtask

  initial begin
    bit seen;
    rd_t snap, now;
    int d0, e0;
    for (int i = 0; i < 256; i++) chain_mem[i] = '0;
    chain_mem[5] = 8'd9; chain_mem[9] = 8'd2; chain_mem[3] = 8'd7;
    ack_pipe = '0;
    for (int i = 0; i < 4; i++) ptr_pipe[i] = '0;
    rst = 1'b1; desc_valid = 1'b0; desc_buf_ptr = '0; desc_port_id = '0;
    desc_len = '0; rd_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_outputs");
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_after_reset", {31'd0, desc_ready}, 32'd1);

    // Single buffer packet.
    send_desc(8'd5, 4'd1, 12'd10);
    wait_idle();

    // Three-buffer chain 5 -> 9 -> 2.
    send_desc(8'd5, 4'd2, 12'd40);
    wait_idle();

    // Exact multiple of buffer size: chain 3 -> 7.
    send_desc(8'd3, 4'd3, 12'd32);
    wait_idle();

    // Zero-length descriptor is dropped.
    d0 = drop_cnt;
    send_desc(8'd7, 4'd4, 12'd0);
    repeat (3) @(negedge clk);
    chk("drop_count", drop_cnt, d0 + 1);
    chk("drop_stays_idle", {31'd0, busy}, 32'd0);

    // Backpressure on the first read command.
    spacing_en = 1'b0;
    rd_ready = 1'b0;
    send_desc(8'd3, 4'd5, 12'd32);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (rd_valid) seen = 1'b1;
    end
    chk("bp_rd_valid", {31'd0, seen}, 32'd1);
    snap = {rd_buf_ptr, rd_port_id, rd_sop, rd_eop, rd_bytes};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      now = {rd_buf_ptr, rd_port_id, rd_sop, rd_eop, rd_bytes};
      chk("bp_stable", {13'd0, rd_valid, now}, {13'd0, 1'b1, snap});
      chk("bp_no_req", {31'd0, buf_req}, 32'd0);
    end
    @(posedge clk); #1 rd_ready = 1'b1;
    wait_idle();
    spacing_en = 1'b1;

    // Reset while waiting for the successor pointer.
    e0 = err_cnt;
    send_desc(8'd5, 4'd6, 12'd40);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (buf_req) seen = 1'b1;
    end
    chk("rst_wait_req_seen", {31'd0, seen}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    exp_rd.delete();
    exp_req.delete();
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset_in_wait");
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("err_ack_count", err_cnt, e0 + 1);
    chk("idle_after_stray_ack", {31'd0, busy}, 32'd0);
    send_desc(8'd9, 4'd7, 12'd16);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/em_buf_chain_reader.md
# em_buf_chain_reader

Walks a packet's buffer chain in edit memory, one buffer at a time. It accepts a packet descriptor (head buffer pointer, port, byte length) and emits one read command per buffer, with SOP/EOP and byte count. It obtains each next pointer by issuing `buf_req` to the edit-memory linked list and waiting for `buf_ack_valid`/`buf_ack_ptr`. It sits on the dequeue side of edit memory, as the requester paired with the linked-list responder.

## Interface
Parameters:
- BPTR_NBITS, `EM_BUF_PTR_NBITS, buffer pointer width
- ID_NBITS, `PORT_ID_NBITS, port id width
- LEN_NBITS, `PD_CHUNK_DEPTH_NBITS, packet length width (bytes)
- SIZE, `DATA_PATH_NBYTES, bytes per buffer
- BC_NBITS, $clog2(SIZE)+1, width of byte count

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  clock
  - `RESET_SIG  in  1  synchronous active-high reset
- Descriptor input:
  - desc_valid  in  1  descriptor present
  - desc_ready  out  1  descriptor accepted when both high
  - desc_buf_ptr  in  BPTR_NBITS  head buffer
  - desc_port_id  in  ID_NBITS  destination port
  - desc_len  in  LEN_NBITS  packet length in bytes
- Linked-list request/acknowledge:
  - buf_req  out  1  next-pointer request, one-cycle pulse
  - buf_req_ptr  out  BPTR_NBITS  buffer whose successor is requested
  - buf_ack_valid  in  1  next pointer returned
  - buf_ack_ptr  in  BPTR_NBITS  successor pointer
- Read command output:
  - rd_valid  out  1  read command present
  - rd_ready  in  1  consumer accepts
  - rd_buf_ptr  out  BPTR_NBITS  buffer to read
  - rd_port_id  out  ID_NBITS  port of packet
  - rd_sop  out  1  first buffer of packet
  - rd_eop  out  1  last buffer of packet
  - rd_bytes  out  BC_NBITS  valid bytes in this buffer (1..SIZE)
- Status:
  - desc_drop  out  1  pulse: zero-length descriptor discarded
  - err_ack  out  1  pulse: buf_ack_valid received outside WAIT
  - busy  out  1  state != IDLE

## Operation
- The FSM has three states: IDLE, EMIT, WAIT.
- IDLE:
  - desc_ready=1.
  - On desc_valid: latch cur_ptr, port, rem=desc_len, and set first=1.
  - desc_len==0: desc_drop pulses the next cycle and the state stays IDLE. No buf_req and no rd are issued.
  - desc_len!=0: go to EMIT.
- EMIT:
  - rd_valid=1 (combinational from state) with rd_buf_ptr=cur_ptr and rd_sop=first.
  - rd_eop=(rem<=SIZE). rd_bytes=rd_eop?rem:SIZE.
  - Outputs are held stable while rd_ready=0.
  - On rd_valid&rd_ready with eop: go to IDLE. The last buffer's link is never requested.
  - On rd_valid&rd_ready without eop: rem<=rem-SIZE, first<=0. Next cycle buf_req=1 with buf_req_ptr=cur_ptr. Go to WAIT.
- WAIT:
  - On buf_ack_valid: cur_ptr<=buf_ack_ptr, go to EMIT.
  - There is no timeout.
- Arithmetic:
  - rem is LEN_NBITS wide.
  - Subtraction occurs only when rem>SIZE, so it never underflows.
  - rd_bytes is rem truncated to BC_NBITS, which is valid because rem<=SIZE at EOP.
- buf_ack_valid in IDLE or EMIT is ignored: no state change, and err_ack pulses one cycle later.
- At most one buf_req is outstanding at any time.
- Reset:
  - All outputs go to 0: desc_ready, buf_req, rd_valid, desc_drop, err_ack, busy.
  - State goes to IDLE.
  - A reset during WAIT abandons the packet. The ack that returns after reset triggers err_ack.

## Timing
- Descriptor handshake at cycle t: rd_valid at t+1.
- EMIT handshake (non-EOP) at t: buf_req at t+1. The linked list acks at t+5 (4-cycle request-to-ack). rd_valid for the next buffer at t+6.
- Steady state, with rd_ready=1: one buffer every 6 cycles.
- EOP handshake at t: IDLE and desc_ready=1 at t+1. Back-to-back packets therefore have 1 bubble.
- buf_req, buf_req_ptr, desc_drop, and err_ack are registered outputs.
- rd_* and desc_ready are decoded from registered state and data.

## Structure
- State encoding lives in local constants.
- The width macros come from defines.vh. No new package entries are needed beyond a shared `EM_CHAIN_ST_NBITS` if other dequeue blocks reuse the FSM encoding.
- Single flat module, with no sub-module. A bench model of the linked list (memory plus 4-cycle ack pipe) lives in the testbench, not the RTL.

## Test plan
All scenarios use SIZE=16.
- Single buffer: desc{ptr=5, len=10}
  - Required: one rd {ptr=5, sop=1, eop=1, bytes=10}, no buf_req, desc_ready high 1 cycle after the rd handshake.
- Three-buffer chain 5→9→2: desc{ptr=5, len=40}
  - Required: buf_req ptr 5 then ptr 9.
  - rd sequence {5, sop, 16}, {9, 16}, {2, eop, 8}.
  - 6-cycle spacing between rd commands.
- Exact multiple: len=32, chain 3→7
  - Required: second rd {7, eop, bytes=16}, exactly one buf_req.
- Zero length: desc len=0
  - Required: desc_drop pulse, no rd_valid, no buf_req, FSM stays IDLE.
- Backpressure: rd_ready=0 for 5 cycles in EMIT
  - Required: rd_* stable, no buf_req until the handshake.
- Reset during WAIT, then ack arrives
  - Required: all outputs 0 after reset, err_ack pulses once, the next descriptor is processed normally.
